// File: rtl/fft256_bitrev_reorder.sv
// Output reorder stage for the 256-point SDF FFT: stores bit-reversed frames in a
// ping-pong RAM and streams each frame out in natural bin order with frame markers.
module fft256_bitrev_reorder #(
    parameter int WIDTH = 32,
    parameter int LOG2N = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [LOG2N-1:0] do_idx,
    output logic             do_first
);

    localparam logic [0:0]       S_IDLE  = 1'b0;
    localparam logic [0:0]       S_READ  = 1'b1;
    localparam logic [LOG2N-1:0] CNT_MAX = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] CNT_ZERO = {LOG2N{1'b0}};
    localparam int               DEPTH   = 2 ** (LOG2N + 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [2*WIDTH-1:0] mem [0:DEPTH-1];

    logic [LOG2N-1:0]   wr_cnt_q, wr_cnt_d;
    logic               wr_bank_q, wr_bank_d;
    logic               frame_done_s;
    logic [LOG2N:0]     wr_addr_s;

    logic [0:0]         state_q, state_d;
    logic               rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]   rd_cnt_q, rd_cnt_d;
    logic               pending_q, pending_d;
    logic               rd_issue_s;

    logic               rd_vld_q, rd_vld_d;
    logic [LOG2N-1:0]   rd_idx_q, rd_idx_d;
    logic [2*WIDTH-1:0] rd_data_q, rd_data_d;

    logic               do_en_q, do_en_d;
    logic [WIDTH-1:0]   do_re_q, do_re_d;
    logic [WIDTH-1:0]   do_im_q, do_im_d;
    logic [LOG2N-1:0]   do_idx_q, do_idx_d;
    logic               do_first_q, do_first_d;

    // Write-side counter and bank select; frame_done fires on the wrapping write.
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        wr_bank_d    = wr_bank_q;
        frame_done_s = 1'b0;
        wr_addr_s    = {wr_bank_q, bitrev(wr_cnt_q)};
        if (di_en) begin
            wr_cnt_d = wr_cnt_q + {{(LOG2N-1){1'b0}}, 1'b1};
            if (wr_cnt_q == CNT_MAX) begin
                wr_bank_d    = ~wr_bank_q;
                frame_done_s = 1'b1;
            end else begin
                wr_bank_d    = wr_bank_q;
                frame_done_s = 1'b0;
            end
        end else begin
            wr_cnt_d  = wr_cnt_q;
            wr_bank_d = wr_bank_q;
        end
    end

    // Read FSM: a frame finishing on the final read chains straight into the other bank.
    always_comb begin
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_cnt_d   = rd_cnt_q;
        pending_d  = pending_q;
        rd_issue_s = (state_q == S_READ);
        case (state_q)
            S_IDLE: begin
                if (frame_done_s) begin
                    state_d   = S_READ;
                    rd_bank_d = wr_bank_q;
                    rd_cnt_d  = CNT_ZERO;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_READ: begin
                rd_cnt_d = rd_cnt_q + {{(LOG2N-1){1'b0}}, 1'b1};
                if (rd_cnt_q == CNT_MAX) begin
                    if (frame_done_s || pending_q) begin
                        rd_bank_d = ~rd_bank_q;
                        pending_d = 1'b0;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else if (frame_done_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // RAM read stage and the hold-when-idle output stage.
    always_comb begin
        rd_vld_d   = rd_issue_s;
        rd_idx_d   = rd_issue_s ? rd_cnt_q : rd_idx_q;
        rd_data_d  = rd_issue_s ? mem[{rd_bank_q, rd_cnt_q}] : rd_data_q;
        do_en_d    = rd_vld_q;
        do_first_d = rd_vld_q && (rd_idx_q == CNT_ZERO);
        if (rd_vld_q) begin
            do_re_d  = rd_data_q[2*WIDTH-1:WIDTH];
            do_im_d  = rd_data_q[WIDTH-1:0];
            do_idx_d = rd_idx_q;
        end else begin
            do_re_d  = do_re_q;
            do_im_d  = do_im_q;
            do_idx_d = do_idx_q;
        end
    end

    // Ping-pong storage write port (contents need no reset).
    always_ff @(posedge clock) begin
        if (di_en) begin
            mem[wr_addr_s] <= {di_re, di_im};
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_cnt_q   <= CNT_ZERO;
            wr_bank_q  <= 1'b0;
            state_q    <= S_IDLE;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= CNT_ZERO;
            pending_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= CNT_ZERO;
            rd_data_q  <= {(2*WIDTH){1'b0}};
            do_en_q    <= 1'b0;
            do_re_q    <= {WIDTH{1'b0}};
            do_im_q    <= {WIDTH{1'b0}};
            do_idx_q   <= CNT_ZERO;
            do_first_q <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            rd_cnt_q   <= rd_cnt_d;
            pending_q  <= pending_d;
            rd_vld_q   <= rd_vld_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
            do_en_q    <= do_en_d;
            do_re_q    <= do_re_d;
            do_im_q    <= do_im_d;
            do_idx_q   <= do_idx_d;
            do_first_q <= do_first_d;
        end
    end

    assign do_en    = do_en_q;
    assign do_re    = do_re_q;
    assign do_im    = do_im_q;
    assign do_idx   = do_idx_q;
    assign do_first = do_first_q;

endmodule

// File: tb/tb_fft256_bitrev_reorder.sv
// Directed bench for fft256_bitrev_reorder: expected bins come from a queue filled
// with the natural-order frame contents before each frame is driven.
module tb_fft256_bitrev_reorder;

    localparam int WIDTH = 32;
    localparam int LOG2N = 8;
    localparam int N     = 256;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             di_en = 1'b0;
    logic [WIDTH-1:0] di_re = 32'd0;
    logic [WIDTH-1:0] di_im = 32'd0;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic [LOG2N-1:0] do_idx;
    logic             do_first;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic [LOG2N-1:0] idx;
        logic             first;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_en = 1'b0;

    fft256_bitrev_reorder #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clock    (clock),
        .reset    (reset),
        .di_en    (di_en),
        .di_re    (di_re),
        .di_im    (di_im),
        .do_en    (do_en),
        .do_re    (do_re),
        .do_im    (do_im),
        .do_idx   (do_idx),
        .do_first (do_first)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] brev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected natural-order content: bin m holds the sample sent at position bitrev(m).
    task automatic push_frame(input logic [31:0] base, input bit rev);
        exp_t e;
        logic [31:0] v;
        for (int m = 0; m < N; m++) begin
            v       = rev ? 32'(m) : {24'd0, brev8(8'(m))};
            e.re    = base + v;
            e.im    = ~(base + v);
            e.idx   = 8'(m);
            e.first = (m == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_samples(input logic [31:0] base, input bit rev, input bit gappy, input int count);
        logic [31:0] v;
        for (int k = 0; k < count; k++) begin
            v     = rev ? {24'd0, brev8(8'(k))} : 32'(k);
            di_en = 1'b1;
            di_re = base + v;
            di_im = ~(base + v);
            @(posedge clock); #1;
            if (gappy) begin
                di_en = 1'b0;
                @(posedge clock); #1;
            end
        end
        di_en = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(posedge clock);
            budget++;
        end
        check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clock);
        #1;
    endtask

    // Output monitor: every valid output must match the next expected bin, with no gap inside a frame.
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1 && do_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 64'(do_idx), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                if (e.idx != 8'd0) check_val("contig", 64'(prev_en), 64'd1);
                check_val("do_re", 64'(do_re), 64'(e.re));
                check_val("do_im", 64'(do_im), 64'(e.im));
                check_val("do_idx", 64'(do_idx), 64'(e.idx));
                check_val("do_first", 64'(do_first), 64'(e.first));
            end
        end
        prev_en = (reset === 1'b1) && (do_en === 1'b1);
    end

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_do_en", 64'(do_en), 64'd0);
        check_val("rst_do_first", 64'(do_first), 64'd0);
        check_val("rst_do_re", 64'(do_re), 64'd0);
        check_val("rst_do_idx", 64'(do_idx), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // 1) plain ramp, with explicit first-output latency checks
        push_frame(32'd0, 1'b0);
        send_samples(32'd0, 1'b0, 1'b0, N);
        @(negedge clock);
        check_val("lat_e0", 64'(do_en), 64'd0);
        @(posedge clock); @(negedge clock);
        check_val("lat_e1", 64'(do_en), 64'd0);
        @(posedge clock); @(negedge clock);
        check_val("lat_e2", 64'(do_en), 64'd1);
        check_val("lat_first", 64'(do_first), 64'd1);
        wait_drain();
        check_val("hold_re", 64'(do_re), 64'd255);

        // 2) bit-reversed ramp comes out as a natural ramp
        push_frame(32'd0, 1'b1);
        send_samples(32'd0, 1'b1, 1'b0, N);
        wait_drain();

        // 3) two frames back to back
        push_frame(32'h1000, 1'b0);
        push_frame(32'hABCD0000, 1'b0);
        send_samples(32'h1000, 1'b0, 1'b0, N);
        send_samples(32'hABCD0000, 1'b0, 1'b0, N);
        wait_drain();

        // 4) gappy input, same result as scenario 1
        push_frame(32'd0, 1'b0);
        send_samples(32'd0, 1'b0, 1'b1, N);
        wait_drain();

        // 5) reset part-way through a frame
        send_samples(32'h5555, 1'b0, 1'b0, 100);
        reset = 1'b0;
        #2;
        check_val("mid_rst_en", 64'(do_en), 64'd0);
        check_val("mid_rst_re", 64'(do_re), 64'd0);
        check_val("mid_rst_im", 64'(do_im), 64'd0);
        check_val("mid_rst_idx", 64'(do_idx), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        push_frame(32'h7700, 1'b0);
        send_samples(32'h7700, 1'b0, 1'b0, N);
        wait_drain();

        // 6) three chained frames: each last write lands on the previous frame's last read
        push_frame(32'h100, 1'b0);
        push_frame(32'h200, 1'b1);
        push_frame(32'h300, 1'b0);
        send_samples(32'h100, 1'b0, 1'b0, N);
        send_samples(32'h200, 1'b1, 1'b0, N);
        send_samples(32'h300, 1'b0, 1'b0, N);
        wait_drain();
        check_val("idle_after", 64'(do_en), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
